// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int n_digits(input int width, input int digit_w);
      return width / digit_w;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit digit_w_ok(input int width, input int digit_w);
      return (digit_w > 0) && (digit_w <= width) && ((width % digit_w) == 0);
   endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational W-bit borrow-ripple subtractor: {bout,d} = x - y - bin.
module sub_digit #(
   parameter int W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] bc;

   assign bc[0] = bin;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign d[gi]      = x[gi] ^ y[gi] ^ bc[gi];
      // Borrow when x<y, or when x==y and a borrow is already pending.
      assign bc[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & bc[gi]);
   end

   assign bout = bc[W];

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial y = a - b with borrow-out, one operation in flight behind valid/ready.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor32
   import sub_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DIGIT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             b_out
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N_DIGITS = n_digits(WIDTH, DIGIT_W);
   localparam int CNT_W    = cnt_width(N_DIGITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

   if (!digit_w_ok(WIDTH, DIGIT_W)) begin : g_bad_digit_w
      $error("serial_subtractor32: WIDTH must be a multiple of DIGIT_W");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               borrow_q, borrow_d;
   logic               b_out_q, b_out_d;
   logic [DIGIT_W-1:0] dig;
   logic               dig_bout;
   logic [WIDTH-1:0]   full_result;
   logic               accept;
   logic               last_digit;

   assign accept     = (state_q == IDLE) && in_valid;
   assign last_digit = (state_q == RUN) && (cnt_q == LAST_CNT);

   sub_digit #(.W(DIGIT_W)) u_digit (
      .x    (a_sh_q[DIGIT_W-1:0]),
      .y    (b_sh_q[DIGIT_W-1:0]),
      .bin  (borrow_q),
      .d    (dig),
      .bout (dig_bout)
   );

   // Only the digits already produced need storage; the current digit completes the word.
   if (N_DIGITS == 1) begin : g_single
      assign full_result = dig;
   end else begin : g_multi
      logic [WIDTH-DIGIT_W-1:0] res_q, res_d;

      assign full_result = {dig, res_q};

      always_comb begin
         res_d = res_q;
         if (state_q == RUN) begin
            res_d = full_result[WIDTH-1:DIGIT_W];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res_q <= '0;
         end else begin
            res_q <= res_d;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      borrow_d = borrow_q;
      y_d      = y_q;
      b_out_d  = b_out_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = RUN;
               a_sh_d   = a;
               b_sh_d   = b;
               cnt_d    = '0;
               borrow_d = 1'b0;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> DIGIT_W;
            b_sh_d   = b_sh_q >> DIGIT_W;
            borrow_d = dig_bout;
            cnt_d    = cnt_q + 1'b1;
            if (last_digit) begin
               state_d = DONE;
               y_d     = full_result;
               b_out_d = dig_bout;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         y_q      <= '0;
         borrow_q <= 1'b0;
         b_out_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         y_q      <= y_d;
         borrow_q <= borrow_d;
         b_out_q  <= b_out_d;
      end
   end

`ifdef SUB_OVF_EN
   // Sign bits are shifted out of the operand registers, so keep them aside.
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;

   always_comb begin
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_msb_d = a[WIDTH-1];
         b_msb_d = b[WIDTH-1];
      end
      if (last_digit) begin
         ovf_d = (a_msb_q != b_msb_q) && (full_result[WIDTH-1] != a_msb_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign b_out     = b_out_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Randomized self-checking bench for serial_subtractor32 against an arithmetic model.
module tb_serial_subtractor32;

   parameter int DIGIT_W = 4;
   localparam int WIDTH  = 32;
   localparam int N      = WIDTH / DIGIT_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  y;
   logic              b_out;
`ifdef SUB_OVF_EN
   logic              ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_subtractor32 #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .b_out     (b_out)
`ifdef SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic model_ovf(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      longint sa, sb, diff;
      sa   = longint'($signed(av));
      sb   = longint'($signed(bv));
      diff = sa - sb;
      return (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
   endfunction

   // Called on a falling edge with the DUT idle; returns on a falling edge with the DUT idle.
   task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int hold);
      logic [WIDTH-1:0] ey;
      logic             eb;
      int               lat;
      ey  = av - bv;
      eb  = (av < bv);
      check("in_ready_idle", in_ready, 1);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      lat      = 0;
      while (!out_valid && lat < 4 * N + 8) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      check("latency", lat, N);
      check("y", y, ey);
      check("b_out", b_out, eb);
`ifdef SUB_OVF_EN
      check("ovf", ovf, model_ovf(av, bv));
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         @(negedge clk);
         check("y_hold", y, ey);
         check("in_ready_done", in_ready, 0);
         check("out_valid_hold", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_hs", out_valid, 0);
      check("y_retained", y, ey);
      $display("op a=%08h b=%08h y=%08h b_out=%0b lat=%0d hold=%0d", av, bv, y, b_out, lat, hold);
   endtask

   task automatic reset_mid_run();
      int seen;
      check("in_ready_pre_rst", in_ready, 1);
      a        = 32'h1234_5678;
      b        = 32'h0000_0001;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat ((N > 3) ? 2 : 0) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_y", y, 0);
      check("rst_b_out", b_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (N + 3) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_out_valid_after_rst", seen, 0);
      $display("op reset during RUN, out_valid pulses afterwards=%0d", seen);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_y", y, 0);
      check("reset_b_out", b_out, 0);
`ifdef SUB_OVF_EN
      check("reset_ovf", ovf, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      do_op(32'd5, 32'd3, 0);
      do_op(32'd0, 32'd1, 0);
      do_op(32'h8000_0000, 32'd1, 0);
      do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(32'h0000_1234, 32'h0000_5678, 5);
      reset_mid_run();
      do_op(32'd10, 32'd10, 0);
      for (int i = 0; i < 200; i++) begin
         do_op($urandom, $urandom, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
